// File: rtl/qdma_2908.sv
// QBUS DMA master for the Am2908 board: arbitrates with TDMR/RDMG/TSACK and runs one
// DATI or DATO per grant, steering the qctl_2908 transceivers through the dma_* strobes.
module qdma_2908 #(
  parameter int ADDR_DESKEW = 3,
  parameter int ADDR_HOLD   = 2,
  parameter int DATA_DESKEW = 2,
  parameter int RD_SETTLE   = 4,
  parameter int TIMEOUT     = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_write,
  input  logic [21:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        ack,
  output logic        nxm,
  output logic [15:0] rdata,
  input  logic [15:0] dal_in,
  input  logic        RDMG,
  output logic        TDMGO,
  output logic        TDMR,
  output logic        TSACK,
  input  logic        RSYNC,
  input  logic        RRPLY,
  output logic        TSYNC,
  output logic        TDIN,
  output logic        TDOUT,
  output logic        dma_assert_dal,
  output logic [21:0] dma_dal,
  output logic        dma_twtbt,
  output logic        dma_daltx,
  output logic        dma_dalst,
  output logic        dma_dalbe
);

  localparam int CW = 8;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, REQ, BUSWAIT, ADDR, AHOLD, WDATA, XFER, RSETTLE, WHOLD, TAIL, RELEASE
  } state_t;

  state_t state, state_d;

  logic [1:0] rdmg_sync, rsync_sync, rrply_sync;
  logic s_rdmg, s_rsync, s_rrply;

  logic [CW-1:0] cnt, cnt_d;
  logic [TW-1:0] tmo, tmo_d;
  logic          wr, wr_d;
  logic [21:0]   addr, addr_d;
  logic [15:0]   wdata, wdata_d;
  logic [15:0]   rbuf, rbuf_d;
  logic          nxm_flag, nxm_flag_d;

  logic tdmgo_d, tdmr_d, tsack_d, tsync_d, tdin_d, tdout_d;
  logic assert_d, twtbt_d, daltx_d, dalst_d, dalbe_d;
  logic [21:0] dal_d;
  logic ack_d, nxm_d;
  logic [15:0] rdata_d;

  logic addr_lsb_unused;
  assign addr_lsb_unused = req_addr[0];

  assign s_rdmg  = rdmg_sync[1];
  assign s_rsync = rsync_sync[1];
  assign s_rrply = rrply_sync[1];

  // Bus inputs arrive from other masters' clock domains.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdmg_sync  <= '0;
      rsync_sync <= '0;
      rrply_sync <= '0;
    end else begin
      rdmg_sync  <= {rdmg_sync[0], RDMG};
      rsync_sync <= {rsync_sync[0], RSYNC};
      rrply_sync <= {rrply_sync[0], RRPLY};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      tmo            <= '0;
      wr             <= 1'b0;
      addr           <= '0;
      wdata          <= '0;
      rbuf           <= '0;
      nxm_flag       <= 1'b0;
      TDMGO          <= 1'b0;
      TDMR           <= 1'b0;
      TSACK          <= 1'b0;
      TSYNC          <= 1'b0;
      TDIN           <= 1'b0;
      TDOUT          <= 1'b0;
      dma_assert_dal <= 1'b0;
      dma_dal        <= '0;
      dma_twtbt      <= 1'b0;
      dma_daltx      <= 1'b0;
      dma_dalst      <= 1'b0;
      dma_dalbe      <= 1'b0;
      ack            <= 1'b0;
      nxm            <= 1'b0;
      rdata          <= '0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      tmo            <= tmo_d;
      wr             <= wr_d;
      addr           <= addr_d;
      wdata          <= wdata_d;
      rbuf           <= rbuf_d;
      nxm_flag       <= nxm_flag_d;
      TDMGO          <= tdmgo_d;
      TDMR           <= tdmr_d;
      TSACK          <= tsack_d;
      TSYNC          <= tsync_d;
      TDIN           <= tdin_d;
      TDOUT          <= tdout_d;
      dma_assert_dal <= assert_d;
      dma_dal        <= dal_d;
      dma_twtbt      <= twtbt_d;
      dma_daltx      <= daltx_d;
      dma_dalst      <= dalst_d;
      dma_dalbe      <= dalbe_d;
      ack            <= ack_d;
      nxm            <= nxm_d;
      rdata          <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    tmo_d      = tmo;
    wr_d       = wr;
    addr_d     = addr;
    wdata_d    = wdata;
    rbuf_d     = rbuf;
    nxm_flag_d = nxm_flag;
    tdmgo_d    = 1'b0;
    tdmr_d     = TDMR;
    tsack_d    = TSACK;
    tsync_d    = TSYNC;
    tdin_d     = TDIN;
    tdout_d    = TDOUT;
    assert_d   = dma_assert_dal;
    dal_d      = dma_dal;
    twtbt_d    = dma_twtbt;
    daltx_d    = dma_daltx;
    dalst_d    = dma_dalst;
    dalbe_d    = dma_dalbe;
    ack_d      = 1'b0;
    nxm_d      = nxm;
    rdata_d    = rdata;

    case (state)
      IDLE: begin
        tdmgo_d = s_rdmg && !req;
        // req is still high in the ack cycle; it belongs to the finished transfer.
        if (req && !ack) begin
          wr_d       = req_write;
          addr_d     = {req_addr[21:1], 1'b0};
          wdata_d    = req_wdata;
          nxm_flag_d = 1'b0;
          tdmr_d     = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (s_rdmg) begin
          tdmr_d  = 1'b0;
          tsack_d = 1'b1;
          state_d = BUSWAIT;
        end
      end
      BUSWAIT: begin
        if (!s_rsync && !s_rrply) begin
          assert_d = 1'b1;
          daltx_d  = 1'b1;
          dal_d    = addr;
          twtbt_d  = wr;
          cnt_d    = '0;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CW'(0)) begin
          dalst_d = 1'b1;
        end else if (cnt == CW'(1)) begin
          dalbe_d = 1'b1;
        end else if (cnt == CW'(ADDR_DESKEW + 1)) begin
          tsync_d = 1'b1;
          cnt_d   = '0;
          state_d = AHOLD;
        end
      end
      AHOLD: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CW'(ADDR_HOLD - 1)) begin
          cnt_d = '0;
          if (wr) begin
            // Drop the strobe so the data load below is a fresh rising edge.
            twtbt_d = 1'b0;
            dal_d   = {6'b0, wdata};
            dalst_d = 1'b0;
            state_d = WDATA;
          end else begin
            dalbe_d  = 1'b0;
            dalst_d  = 1'b0;
            daltx_d  = 1'b0;
            assert_d = 1'b0;
            twtbt_d  = 1'b0;
            dal_d    = '0;
            tdin_d   = 1'b1;
            tmo_d    = '0;
            state_d  = XFER;
          end
        end
      end
      WDATA: begin
        cnt_d   = cnt + 1'b1;
        dalst_d = (cnt == CW'(0));
        if (cnt == CW'(DATA_DESKEW)) begin
          tdout_d = 1'b1;
          tmo_d   = '0;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        tmo_d = tmo + 1'b1;
        if (s_rrply) begin
          cnt_d = '0;
          if (wr) begin
            tdout_d = 1'b0;
            state_d = WHOLD;
          end else begin
            state_d = RSETTLE;
          end
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          tdin_d     = 1'b0;
          tdout_d    = 1'b0;
          assert_d   = 1'b0;
          dal_d      = '0;
          twtbt_d    = 1'b0;
          daltx_d    = 1'b0;
          dalst_d    = 1'b0;
          dalbe_d    = 1'b0;
          nxm_flag_d = 1'b1;
          state_d    = TAIL;
        end
      end
      RSETTLE: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CW'(RD_SETTLE - 1)) begin
          rbuf_d  = dal_in;
          tdin_d  = 1'b0;
          state_d = TAIL;
        end
      end
      WHOLD: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CW'(1)) begin
          dalbe_d  = 1'b0;
          dalst_d  = 1'b0;
          daltx_d  = 1'b0;
          assert_d = 1'b0;
          dal_d    = '0;
          state_d  = TAIL;
        end
      end
      TAIL: begin
        if (!s_rrply) begin
          tsync_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        tsack_d = 1'b0;
        ack_d   = 1'b1;
        nxm_d   = nxm_flag;
        if (!nxm_flag && !wr) rdata_d = rbuf;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_qdma_2908.sv
// Directed bench for qdma_2908: acts as QBUS arbiter/slave and scoreboards each ack
// against the result queued when the request was issued.
module tb_qdma_2908;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, req_write;
  logic [21:0] req_addr;
  logic [15:0] req_wdata;
  logic        ack, nxm;
  logic [15:0] rdata;
  logic [15:0] dal_in;
  logic        RDMG, TDMGO, TDMR, TSACK, RSYNC, RRPLY, TSYNC, TDIN, TDOUT;
  logic        dma_assert_dal, dma_twtbt, dma_daltx, dma_dalst, dma_dalbe;
  logic [21:0] dma_dal;

  qdma_2908 dut (
    .clk(clk), .reset(reset), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .nxm(nxm), .rdata(rdata), .dal_in(dal_in),
    .RDMG(RDMG), .TDMGO(TDMGO), .TDMR(TDMR), .TSACK(TSACK), .RSYNC(RSYNC), .RRPLY(RRPLY),
    .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT), .dma_assert_dal(dma_assert_dal),
    .dma_dal(dma_dal), .dma_twtbt(dma_twtbt), .dma_daltx(dma_daltx),
    .dma_dalst(dma_dalst), .dma_dalbe(dma_dalbe)
  );

  always #5 clk = ~clk;

  localparam int S_TDMR = 0, S_TSACK = 1, S_TDIN = 2, S_TDOUT = 3, S_ACK = 4, S_TDMGO = 5;

  typedef struct {
    logic        check_rdata;
    logic        nxm;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Edge timestamps and invariant violations observed on the falling edge.
  int          ncyc = 0, viol = 0;
  int          dalbe_t = 0, tsync_t = 0, dstb_t = 0, tdout_t = 0, tdin_t = 0, tdin_fall_t = 0;
  logic        p_dalbe = 0, p_tsync = 0, p_dalst = 0, p_tdin = 0, p_tdout = 0;
  logic [21:0] addr_dal = '0, data_dal = '0;
  logic        addr_twtbt = 0, data_twtbt = 0;

  always @(negedge clk) begin
    ncyc    <= ncyc + 1;
    p_dalbe <= dma_dalbe;
    p_tsync <= TSYNC;
    p_dalst <= dma_dalst;
    p_tdin  <= TDIN;
    p_tdout <= TDOUT;
    if (dma_dalbe && !p_dalbe) begin
      dalbe_t    <= ncyc;
      addr_dal   <= dma_dal;
      addr_twtbt <= dma_twtbt;
    end
    if (dma_dalst && !p_dalst && dma_dalbe) begin
      dstb_t     <= ncyc;
      data_dal   <= dma_dal;
      data_twtbt <= dma_twtbt;
    end
    if (TSYNC && !p_tsync) tsync_t <= ncyc;
    if (TDOUT && !p_tdout) tdout_t <= ncyc;
    if (TDIN && !p_tdin) tdin_t <= ncyc;
    if (!TDIN && p_tdin) tdin_fall_t <= ncyc;
    if ((TDIN && TDOUT) || (TDIN && dma_daltx) || (dma_dalbe && !(dma_daltx && dma_assert_dal)))
      viol <= viol + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      S_TDMR:  return TDMR;
      S_TSACK: return TSACK;
      S_TDIN:  return TDIN;
      S_TDOUT: return TDOUT;
      S_ACK:   return ack;
      default: return TDMGO;
    endcase
  endfunction

  task automatic waitFor(input int sel, input logic lvl, input int budget, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (pick(sel) === lvl) seen = 1'b1;
    end
    checkOutput(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic applyStimulus(input logic wr, input logic [21:0] a, input logic [15:0] d,
                               input logic expect_ack, input logic exp_nxm, input logic [15:0] exp_rd);
    exp_t e;
    @(negedge clk);
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req       = 1'b1;
    e.check_rdata = !wr && !exp_nxm;
    e.nxm         = exp_nxm;
    e.rdata       = exp_rd;
    if (expect_ack) sb.push_back(e);
  endtask

  task automatic awaitAck(input string tag);
    exp_t e;
    waitFor(S_ACK, 1'b1, 60, {tag, "_ack"});
    req = 1'b0;
    checkOutput({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_nxm"}, {31'b0, nxm}, {31'b0, e.nxm});
      if (e.check_rdata) checkOutput({tag, "_rdata"}, {16'b0, rdata}, {16'b0, e.rdata});
    end
  endtask

  task automatic doRead(input string tag, input logic [21:0] a, input logic [15:0] d);
    applyStimulus(1'b0, a, 16'h0, 1'b1, 1'b0, d);
    waitFor(S_TDMR, 1'b1, 10, {tag, "_tdmr"});
    RDMG = 1'b1;
    waitFor(S_TSACK, 1'b1, 10, {tag, "_tsack"});
    RDMG = 1'b0;
    waitFor(S_TDIN, 1'b1, 40, {tag, "_tdin"});
    dal_in = d;
    RRPLY  = 1'b1;
    waitFor(S_TDIN, 1'b0, 20, {tag, "_tdin_off"});
    RRPLY = 1'b0;
    awaitAck(tag);
  endtask

  function automatic logic [31:0] ctrlBits();
    return {19'b0, TDMGO, TDMR, TSACK, TSYNC, TDIN, TDOUT, ack, nxm,
            dma_assert_dal, dma_twtbt, dma_daltx, dma_dalst, dma_dalbe};
  endfunction

  initial begin
    logic [31:0] acc;
    reset = 1'b1; req = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    dal_in = '0; RDMG = 1'b0; RSYNC = 1'b0; RRPLY = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", ctrlBits(), 32'd0);
    checkOutput("reset_dal", {10'b0, dma_dal}, 32'd0);
    checkOutput("reset_rdata", {16'b0, rdata}, 32'd0);
    reset = 1'b0;

    // DATI with a normal reply
    doRead("dati", 22'h001FFE, 16'hA5C3);
    checkOutput("dati_addr", {10'b0, addr_dal}, 32'h1FFE);
    checkOutput("dati_twtbt", {31'b0, addr_twtbt}, 32'd0);
    checkOutput("dati_tsync_skew", tsync_t - dalbe_t, 32'd3);

    // DATO
    applyStimulus(1'b1, 22'h3FF000, 16'h1234, 1'b1, 1'b0, 16'h0);
    waitFor(S_TDMR, 1'b1, 10, "dato_tdmr");
    RDMG = 1'b1;
    waitFor(S_TSACK, 1'b1, 10, "dato_tsack");
    checkOutput("dato_tdmr_off", {31'b0, TDMR}, 32'd0);
    RDMG = 1'b0;
    waitFor(S_TDOUT, 1'b1, 40, "dato_tdout");
    RRPLY = 1'b1;
    waitFor(S_TDOUT, 1'b0, 20, "dato_tdout_off");
    RRPLY = 1'b0;
    awaitAck("dato");
    checkOutput("dato_addr", {10'b0, addr_dal}, 32'h3FF000);
    checkOutput("dato_addr_twtbt", {31'b0, addr_twtbt}, 32'd1);
    checkOutput("dato_data", {10'b0, data_dal}, 32'h1234);
    checkOutput("dato_data_twtbt", {31'b0, data_twtbt}, 32'd0);
    checkOutput("dato_tdout_skew", tdout_t - dstb_t, 32'd2);

    // No reply: NXM after the timeout
    applyStimulus(1'b0, 22'h000200, 16'h0, 1'b1, 1'b1, 16'h0);
    waitFor(S_TDMR, 1'b1, 10, "nxm_tdmr");
    RDMG = 1'b1;
    waitFor(S_TSACK, 1'b1, 10, "nxm_tsack");
    RDMG = 1'b0;
    waitFor(S_TDIN, 1'b1, 40, "nxm_tdin");
    waitFor(S_TDIN, 1'b0, 210, "nxm_tdin_off");
    awaitAck("nxm");
    checkOutput("nxm_tdin_width", tdin_fall_t - tdin_t, 32'd200);
    checkOutput("nxm_release", {30'b0, TSACK, TSYNC}, 32'd0);

    // Grant pass-through while idle
    RDMG = 1'b1;
    waitFor(S_TDMGO, 1'b1, 6, "pass_on");
    RDMG = 1'b0;
    waitFor(S_TDMGO, 1'b0, 6, "pass_off");

    // Bus still busy with another master's SYNC after the grant
    RSYNC = 1'b1;
    applyStimulus(1'b0, 22'h000101, 16'h0, 1'b1, 1'b0, 16'h0F0F);
    waitFor(S_TDMR, 1'b1, 10, "busy_tdmr");
    RDMG = 1'b1;
    waitFor(S_TSACK, 1'b1, 10, "busy_tsack");
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = acc | {9'b0, TDMGO, TSYNC, dma_assert_dal, dma_twtbt, dma_daltx, dma_dalst, dma_dalbe, dma_dal != 22'd0};
    end
    checkOutput("busy_quiet", acc, 32'd0);
    RDMG  = 1'b0;
    RSYNC = 1'b0;
    waitFor(S_TDIN, 1'b1, 40, "busy_tdin");
    dal_in = 16'h0F0F;
    RRPLY  = 1'b1;
    waitFor(S_TDIN, 1'b0, 20, "busy_tdin_off");
    RRPLY = 1'b0;
    awaitAck("busy");
    checkOutput("busy_addr_lsb", {10'b0, addr_dal}, 32'h000100);

    // Reset during a write data phase
    applyStimulus(1'b1, 22'h000400, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    waitFor(S_TDMR, 1'b1, 10, "rst_tdmr");
    RDMG = 1'b1;
    waitFor(S_TSACK, 1'b1, 10, "rst_tsack");
    RDMG = 1'b0;
    waitFor(S_TDOUT, 1'b1, 40, "rst_tdout");
    reset = 1'b1;
    req   = 1'b0;
    @(negedge clk);
    checkOutput("rst_ctrl", ctrlBits(), 32'd0);
    checkOutput("rst_dal", {10'b0, dma_dal}, 32'd0);
    checkOutput("rst_rdata", {16'b0, rdata}, 32'd0);
    reset = 1'b0;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc = acc | {31'b0, ack};
    end
    checkOutput("rst_no_ack", acc, 32'd0);
    doRead("after_rst", 22'h000600, 16'h7E57);

    checkOutput("sb_drained", sb.size(), 32'd0);
    checkOutput("invariants", viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qdma_2908.md
Name: qdma_2908

Overview:
- QBUS DMA master for the PMo/Ztex Am2908 board.
- Accepts single-word read/write requests from an on-chip client (storage controller) and arbitrates for the bus with TDMR/RDMG/TSACK.
- Runs one DATI or DATO cycle per grant.
- Sequences the Am2908 transceivers through the qctl_2908 dma_* inputs: dma_daltx, then dma_dalst, then dma_dalbe.
- Reports read data, or a non-existent-memory (NXM) error on reply timeout.

Parameters:
- ADDR_DESKEW, 3: clocks the address is driven on BDAL before TSYNC is asserted (150 ns at 20 MHz).
- ADDR_HOLD, 2: clocks the address stays on BDAL after TSYNC is asserted.
- DATA_DESKEW, 2: clocks write data is on BDAL before TDOUT is asserted.
- RD_SETTLE, 4: clocks after synchronized RRPLY before read data is sampled.
- TIMEOUT, 200: clocks to wait for RRPLY before declaring NXM (10 us).

Ports:
- clk  in  1  20 MHz clock
- reset  in  1  synchronous, active-high
- req  in  1  client request; held until ack
- req_write  in  1  1 = DATO, 0 = DATI; sampled with req
- req_addr  in  22  word address; bit 0 ignored and driven as 0
- req_wdata  in  16  write data
- ack  out  1  one-clock pulse; the transfer is complete
- nxm  out  1  valid with ack; 1 = no RRPLY within TIMEOUT
- rdata  out  16  read data; valid with ack when !nxm, held until the next ack
- dal_in  in  16  receive side of ZDAL[15:0]
- RDMG  in  1  DMA grant in (asynchronous)
- TDMGO  out  1  DMA grant passed down the daisy chain
- TDMR  out  1  DMA request
- TSACK  out  1  select acknowledge
- RSYNC  in  1  bus SYNC (asynchronous)
- RRPLY  in  1  bus RPLY (asynchronous)
- TSYNC, TDIN, TDOUT  out  1 each  bus master strobes
- dma_assert_dal  out  1  to qctl_2908
- dma_dal  out  22  to qctl_2908
- dma_twtbt  out  1  to qctl_2908
- dma_daltx  out  1  to qctl_2908
- dma_dalst  out  1  to qctl_2908
- dma_dalbe  out  1  to qctl_2908

Behaviour:
- Clock and reset:
  - Single clock domain on clk.
  - reset is synchronous and active-high. It forces state IDLE, all outputs 0 and rdata 0, and clears synchronizers and counters.
  - Reset mid-cycle drops every bus signal on the next edge and issues no ack.
- Synchronizers: RDMG, RSYNC and RRPLY each pass through 2 flops. sX denotes the synchronized value.
- Grant daisy chain: TDMGO = sRDMG when the state is IDLE or REQ and the grant is not being accepted; otherwise 0. In IDLE with no req, the grant is passed through.
- IDLE: on req, latch req_write, req_addr and req_wdata; assert TDMR; go to REQ.
- REQ:
  - On sRDMG, assert TSACK and negate TDMR in the same edge, then go to BUSWAIT.
  - The grant is not propagated in the clock it is accepted.
- BUSWAIT:
  - Wait until sRSYNC == 0 and sRRPLY == 0, so the previous master is finished.
  - Then dma_assert_dal = 1, dma_daltx = 1, dma_dal = latched address, dma_twtbt = req_write. Go to ADDR.
- ADDR:
  - 1st clock: dma_dalst = 1.
  - 2nd clock: dma_dalbe = 1.
  - Then count ADDR_DESKEW clocks, assert TSYNC, and go to AHOLD.
  - dma_dalst stays 1 while dma_dalbe is 1.
- AHOLD: count ADDR_HOLD clocks, then:
  - Read: clear dma_dalbe, dma_dalst, dma_daltx, dma_assert_dal and dma_twtbt; assert TDIN; go to XFER.
  - Write: clear dma_twtbt; set dma_dal = {6'b0, wdata}; pulse dma_dalst for 1 clock with dma_dalbe held; count DATA_DESKEW; assert TDOUT; go to XFER.
- XFER:
  - Timeout counter starts at 0 on entry.
  - On sRRPLY:
    - Read: wait RD_SETTLE, capture rdata = dal_in, negate TDIN.
    - Write: negate TDOUT, hold data 2 more clocks, then clear dma_dalbe, dma_dalst, dma_daltx and dma_assert_dal.
    - Go to TAIL.
  - Counter reaches TIMEOUT without sRRPLY: negate TDIN/TDOUT and all dma_* outputs, set the nxm flag, go to TAIL.
- TAIL:
  - Wait sRRPLY == 0; on a timeout the condition is already satisfied.
  - Negate TSYNC, negate TSACK on the next clock, pulse ack with nxm, go to IDLE.
  - req may be reasserted immediately after ack.
- Invariants:
  - One transfer per grant.
  - Only one of TDIN and TDOUT is asserted at a time.
  - dma_dalbe implies dma_daltx and dma_assert_dal.
  - No dma_* output is asserted outside BUSWAIT..XFER.

Test Plan:
1. DATI: req_addr = 0o017776 (0x1FFE), write = 0; bench grants RDMG and replies RRPLY with dal_in = 0xA5C3 → ack with rdata = 0xA5C3, nxm = 0. Check TSYNC is asserted exactly ADDR_DESKEW clocks after dma_dalbe, and TDIN is never overlapped with dma_daltx.
2. DATO: addr = 0x3FF000, wdata = 0x1234 → dma_dal shows the address with dma_twtbt = 1, then {6'b0, 0x1234} with dma_twtbt = 0. TDOUT is asserted DATA_DESKEW clocks after the data dalst pulse. ack with nxm = 0.
3. No reply: DATI with RRPLY never asserted → TDIN drops 200 clocks after assertion; ack with nxm = 1; TSACK and TSYNC released.
4. Grant pass-through and bus busy:
   - RDMG pulsed while idle → TDMGO follows sRDMG.
   - Request with RSYNC held high after grant → BUSWAIT holds with no dma_* output until RSYNC drops; TDMGO stays 0 after acceptance.
5. Reset mid-XFER (write, TDOUT asserted) → next edge: all outputs 0, no ack; a subsequent req completes normally.
